// File: rtl/alu_res_wb.sv
// alu_res_wb: ALU result write-back engine.
// Captures each ALU result together with its opcode into a small FIFO and
// writes the results, in arrival order, to a result memory through a req/ack
// handshake.  The write address auto-increments and wraps silently.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   res_in          ALU result (2*DATA_WIDTH bits, forwarded unmodified)
//   oper_in         opcode that produced the result
//   res_valid       one-cycle pulse: res_in/oper_in valid this cycle
//   wr_req          write request to result memory (held until wr_ack)
//   wr_addr         write address (AW bits, wraps RES_DEPTH-1 -> 0)
//   wr_data         write data
//   wr_oper         opcode tag written with the data
//   wr_ack          memory accepted the write this cycle (ignored in IDLE)
//   fifo_count      entries currently held, including the one being written
//   overflow        sticky: a result was dropped because the FIFO was full
//   wr_done_cnt     completed writes, saturating at 16'hFFFF
module alu_res_wb #(
    parameter int DATA_WIDTH = 8,
    parameter int OPER_WIDTH = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RES_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2*DATA_WIDTH-1:0]         res_in,
    input  logic [OPER_WIDTH-1:0]           oper_in,
    input  logic                            res_valid,
    output logic                            wr_req,
    output logic [$clog2(RES_DEPTH)-1:0]    wr_addr,
    output logic [2*DATA_WIDTH-1:0]         wr_data,
    output logic [OPER_WIDTH-1:0]           wr_oper,
    input  logic                            wr_ack,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [15:0]                     wr_done_cnt
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int EW = RW + OPER_WIDTH;
    localparam int AW = $clog2(RES_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic          full, empty, pop, push, drop, load;

    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign empty = (fifo_count == '0);
    assign pop   = (state == REQ) && wr_ack;
    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is still accepted then.
    assign push  = res_valid && (!full || pop);
    assign drop  = res_valid && full && !pop;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                // Decision uses the registered (pre-push) count.
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage needs no reset; emptiness is defined by the pointers/count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[tail] <= {oper_in, res_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_oper     <= '0;
            wr_done_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wr_req <= (state_nxt == REQ);

            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end

            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end

            if (load) begin
                {wr_oper, wr_data} <= fifo_mem[head];
            end

            if (pop) begin
                wr_addr <= (wr_addr == AW'(RES_DEPTH - 1)) ? '0 : wr_addr + 1'b1;
                if (wr_done_cnt != 16'hFFFF) begin
                    wr_done_cnt <= wr_done_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_res_wb.sv
// Self-checking bench for alu_res_wb.  A behavioural model (a queue of
// pending writes with their target addresses) tracks what the memory should
// see; a monitor compares the DUT against it every cycle.
module tb_alu_res_wb;

    logic        clk;
    logic        reset;
    logic [15:0] res_in;
    logic [1:0]  oper_in;
    logic        res_valid;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_oper;
    logic        wr_ack;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] wr_done_cnt;

    alu_res_wb #(
        .DATA_WIDTH(8),
        .OPER_WIDTH(2),
        .FIFO_DEPTH(4),
        .RES_DEPTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .res_in     (res_in),
        .oper_in    (oper_in),
        .res_valid  (res_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_oper    (wr_oper),
        .wr_ack     (wr_ack),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .wr_done_cnt(wr_done_cnt)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [1:0]  oper;
        logic [15:0] data;
    } wr_t;

    wr_t         sbq[$];       // accepted results not yet written
    logic        req_m;        // model: a write request is outstanding
    logic        ovf_m;
    int unsigned done_m;
    int unsigned next_addr;    // address the next accepted result will get
    logic        mon_en;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updated on each rising edge from the bench inputs only.
    initial begin
        req_m     = 1'b0;
        ovf_m     = 1'b0;
        done_m    = 0;
        next_addr = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                sbq.delete();
                req_m     = 1'b0;
                ovf_m     = 1'b0;
                done_m    = 0;
                next_addr = 0;
            end else begin
                int  n_pre;
                logic popped;
                n_pre  = sbq.size();
                popped = 1'b0;
                if (req_m) begin
                    if (wr_ack) begin
                        void'(sbq.pop_front());
                        popped = 1'b1;
                        if (done_m < 65535) done_m++;
                        req_m = 1'b0;
                    end
                end else if (n_pre > 0) begin
                    req_m = 1'b1;
                end
                if (res_valid) begin
                    if (n_pre < 4 || popped) begin
                        sbq.push_back('{addr: 4'(next_addr), oper: oper_in, data: res_in});
                        next_addr = (next_addr + 1) % 16;
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT against the model shortly after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("wr_req", 32'(wr_req), 32'(req_m));
                chk("fifo_count", 32'(fifo_count), 32'(sbq.size()));
                chk("overflow", 32'(overflow), 32'(ovf_m));
                chk("wr_done_cnt", 32'(wr_done_cnt), done_m);
                if (wr_req) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=req_with_no_pending expected=idle at %0t", $time);
                    end else begin
                        chk("wr_addr", 32'(wr_addr), 32'(sbq[0].addr));
                        chk("wr_data", 32'(wr_data), 32'(sbq[0].data));
                        chk("wr_oper", 32'(wr_oper), 32'(sbq[0].oper));
                    end
                end
            end
        end
    end

    // Drive inputs for one cycle; returns 3 time units after the consuming edge.
    task automatic step(input logic v, input logic [15:0] r, input logic [1:0] o, input logic a);
        res_valid = v;
        res_in    = r;
        oper_in   = o;
        wr_ack    = a;
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'h0, 2'd0, 1'b0);
        step(1'b0, 16'h0, 2'd0, 1'b0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_oper", 32'(wr_oper), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done", 32'(wr_done_cnt), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        res_valid = 1'b0;
        res_in    = '0;
        oper_in   = '0;
        wr_ack    = 1'b0;
        @(posedge clk);
        #3;
        do_reset();
        mon_en = 1'b1;

        // 1: single result latency
        step(1'b1, 16'h00F0, 2'd2, 1'b0);
        chk("t1_req_t1", 32'(wr_req), 32'd0);
        step(1'b0, 16'h0, 2'd0, 1'b0);
        chk("t1_req_t2", 32'(wr_req), 32'd1);
        chk("t1_addr", 32'(wr_addr), 32'd0);
        chk("t1_data", 32'(wr_data), 32'h00F0);
        chk("t1_oper", 32'(wr_oper), 32'd2);
        step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("t1_req_t3", 32'(wr_req), 32'd0);
        chk("t1_done", 32'(wr_done_cnt), 32'd1);
        chk("t1_count", 32'(fifo_count), 32'd0);

        // 2: ack stall with three queued results
        do_reset();
        step(1'b1, 16'h0001, 2'd1, 1'b0);
        step(1'b1, 16'h0002, 2'd2, 1'b0);
        step(1'b1, 16'h0003, 2'd3, 1'b0);
        step(1'b0, 16'h0, 2'd0, 1'b0);
        step(1'b0, 16'h0, 2'd0, 1'b0);
        chk("t2_count", 32'(fifo_count), 32'd3);
        chk("t2_req", 32'(wr_req), 32'd1);
        chk("t2_data", 32'(wr_data), 32'h0001);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("t2_done", 32'(wr_done_cnt), 32'd3);
        chk("t2_addr_next", 32'(wr_addr), 32'd3);

        // 3: overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'(16'h0A00 + i), 2'(i), 1'b0);
            if (i == 3) chk("t3_ovf_before", 32'(overflow), 32'd0);
            if (i >= 4) chk("t3_ovf_after", 32'(overflow), 32'd1);
        end
        chk("t3_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("t3_done", 32'(wr_done_cnt), 32'd4);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0B00 + i), 2'(i), 1'b0);
        chk("t4_full_req", 32'(wr_req), 32'd1);
        step(1'b1, 16'h0055, 2'd1, 1'b1);
        chk("t4_count", 32'(fifo_count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("t4_done", 32'(wr_done_cnt), 32'd5);

        // 5: address wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 16'(i * 3 + 7), 2'(i), 1'b1);
            step(1'b0, 16'h0, 2'd0, 1'b1);
            step(1'b0, 16'h0, 2'd0, 1'b1);
            step(1'b0, 16'h0, 2'd0, 1'b1);
        end
        chk("t5_done", 32'(wr_done_cnt), 32'd17);
        chk("t5_addr", 32'(wr_addr), 32'd1);

        // 6: reset in the middle of a request
        do_reset();
        step(1'b1, 16'h1111, 2'd1, 1'b0);
        step(1'b1, 16'h2222, 2'd2, 1'b0);
        chk("t6_req", 32'(wr_req), 32'd1);
        reset = 1'b1;
        step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("t6_req_rst", 32'(wr_req), 32'd0);
        chk("t6_count_rst", 32'(fifo_count), 32'd0);
        chk("t6_addr_rst", 32'(wr_addr), 32'd0);
        chk("t6_ovf_rst", 32'(overflow), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("t6_no_write", 32'(wr_done_cnt), 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 4), 16'($urandom), 2'($urandom), ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 2'd0, 1'b1);
        chk("rand_drained", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
